lpfilt_capture_reader: RTL and testbench

- Sits downstream of the Shannon-Whittaker low-pass filter and consumes its 8-samples-per-clock output.
- On arm + trigger, captures DEPTH consecutive valid filter words into an internal buffer.
- After capture, reads the buffer out as a 128-bit AXI4-Stream, with each sample sign-extended to 16 bits.
- Used by software/ILA readback to compare filter output against the FIR IP reference.

---
 rtl/lpfilt_capture_pkg.sv | 45 ++++
 rtl/lpfilt_capture_ram.sv | 30 +++
 rtl/lpfilt_capture_reader.sv | 191 +++++++++++++++++++
 tb/tb_lpfilt_capture_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpfilt_capture_pkg.sv
// Shared types and helpers for the low-pass filter capture reader.
//   state_t    : capture/readout FSM states
//   AXIS_LANE  : width of one sample lane on the output stream
//   sext_pack  : sign-extends NSAMP packed NBITS samples into AXIS_LANE lanes
package lpfilt_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } state_t;

  localparam int AXIS_LANE     = 16;

  // sext_pack works on fixed maximum-width vectors so it can serve any
  // NBITS <= AXIS_LANE and NSAMP <= PACK_MAX_SAMP; callers zero-extend the
  // input and truncate the result to their own widths.
  localparam int PACK_MAX_SAMP = 16;
  localparam int PACK_MAX_IN   = PACK_MAX_SAMP * AXIS_LANE;
  localparam int PACK_MAX_OUT  = PACK_MAX_SAMP * AXIS_LANE;
  localparam int PACK_IDX_W    = $clog2(PACK_MAX_IN);

  // Each lane takes its sign bit from its own sample's MSB.
  function automatic logic [PACK_MAX_OUT-1:0] sext_pack(
    input logic [PACK_MAX_IN-1:0] din,
    input int                     nbits,
    input int                     nsamp
  );
    logic [PACK_MAX_OUT-1:0] res;
    res = '0;
    for (int k = 0; k < PACK_MAX_SAMP; k++) begin
      for (int b = 0; b < AXIS_LANE; b++) begin
        if (k < nsamp) begin
          if (b < nbits)
            res[PACK_IDX_W'(AXIS_LANE*k + b)] = din[PACK_IDX_W'(nbits*k + b)];
          else
            res[PACK_IDX_W'(AXIS_LANE*k + b)] = din[PACK_IDX_W'(nbits*k + nbits - 1)];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lpfilt_capture_ram.sv
// Simple dual-port capture buffer, DEPTH words of WIDTH bits.
//   clk_i            : clock for both ports
//   wr_en/addr/data  : synchronous write port
//   rd_en/addr       : read request; rd_data valid the cycle after rd_en
// Contents are not reset.
module lpfilt_capture_ram
  import lpfilt_capture_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 96
) (
  input  logic                     clk_i,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lpfilt_capture_reader.sv
// Captures DEPTH consecutive valid filter words after arm + trigger, then
// replays them as a 128-bit AXI4-Stream with each sample sign-extended.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   dat_i, dat_valid_i    : filter output word (NSAMP x NBITS) and its valid
//   arm_i, trig_i         : arm request, trigger
//   m_axis_*              : AXI4-Stream master (tlast on beat DEPTH-1)
//   busy_o                : not idle
//   done_o                : one-cycle pulse after the final beat is accepted
module lpfilt_capture_reader
  import lpfilt_capture_pkg::*;
#(
  parameter int NBITS = 12,
  parameter int NSAMP = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NSAMP*NBITS-1:0]     dat_i,
  input  logic                       dat_valid_i,
  input  logic                       arm_i,
  input  logic                       trig_i,
  output logic [NSAMP*AXIS_LANE-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IN_W  = NSAMP * NBITS;
  localparam int OUT_W = NSAMP * AXIS_LANE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t state_reg, state_next;

  logic [AW-1:0]    wr_cnt_reg, rd_cnt_reg;
  logic             rd_done_reg;
  logic             rd_pend_reg, rd_pend_last_reg;
  logic             skid_valid_reg, skid_last_reg;
  logic [OUT_W-1:0] skid_data_reg;
  logic             out_valid_reg, out_last_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             done_reg;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             rd_issue;
  logic             pop;
  logic             final_beat;
  logic [1:0]       occ;
  logic [IN_W-1:0]  ram_rd_data;
  logic [OUT_W-1:0] land_data;

  lpfilt_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IN_W)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (dat_i),
    .rd_en   (rd_issue),
    .rd_addr (rd_cnt_reg),
    .rd_data (ram_rd_data)
  );

  assign land_data  = OUT_W'(sext_pack(PACK_MAX_IN'(ram_rd_data), NBITS, NSAMP));
  assign pop        = out_valid_reg & m_axis_tready;
  assign final_beat = pop & out_last_reg;

  // Words held or in flight after this cycle's pop. A new read is issued only
  // if the output and skid registers can still absorb it when it lands, so a
  // stalled sink never loses data and a ready sink sees one beat per clock.
  assign occ      = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg}
                  + {1'b0, rd_pend_reg} - {1'b0, pop};
  assign rd_issue = (state_reg == READOUT) && !rd_done_reg && (occ < 2'd2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (arm_i)
          state_next = ARMED;
      end
      ARMED: begin
        if (trig_i && dat_valid_i) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (dat_valid_i) begin
          wr_en = 1'b1;
          if (wr_cnt_reg == LAST_ADDR)
            state_next = READOUT;
        end
      end
      READOUT: begin
        if (final_beat)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture/read counters; both saturate at the last address so they never
  // wrap inside one capture, and clear when the final beat returns us to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_reg       <= '0;
      rd_cnt_reg       <= '0;
      rd_done_reg      <= 1'b0;
      rd_pend_reg      <= 1'b0;
      rd_pend_last_reg <= 1'b0;
    end else begin
      if (final_beat) begin
        wr_cnt_reg  <= '0;
        rd_cnt_reg  <= '0;
        rd_done_reg <= 1'b0;
      end else begin
        if (state_reg == ARMED && trig_i && dat_valid_i)
          wr_cnt_reg <= AW'(1);
        else if (state_reg == CAPTURE && dat_valid_i && wr_cnt_reg != LAST_ADDR)
          wr_cnt_reg <= wr_cnt_reg + 1'b1;
        if (rd_issue) begin
          if (rd_cnt_reg == LAST_ADDR)
            rd_done_reg <= 1'b1;
          else
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
        end
      end
      rd_pend_reg      <= rd_issue;
      rd_pend_last_reg <= rd_issue && (rd_cnt_reg == LAST_ADDR);
    end
  end

  // Two-entry queue: output register in front, skid register behind it.
  // RAM data landing this cycle goes to whichever slot is next in order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= final_beat;
      if (!out_valid_reg || pop) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= rd_pend_reg;
          skid_data_reg  <= land_data;
          skid_last_reg  <= rd_pend_last_reg;
        end else if (rd_pend_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= land_data;
          out_last_reg  <= rd_pend_last_reg;
        end else begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
      end else if (rd_pend_reg) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= land_data;
        skid_last_reg  <= rd_pend_last_reg;
      end
    end
  end

  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tlast  = out_last_reg;
  assign busy_o        = (state_reg != IDLE);
  assign done_o        = done_reg;

endmodule

// File: tb/tb_lpfilt_capture_reader.sv
// Self-checking bench for lpfilt_capture_reader: table of hand-computed
// sign-extension vectors plus randomized captures checked against a
// behavioural model of capture order and per-sample sign extension.
module tb_lpfilt_capture_reader;

  localparam int NBITS = 12;
  localparam int NSAMP = 8;
  localparam int DEPTH = 64;
  localparam int IN_W  = NSAMP * NBITS;
  localparam int OUT_W = NSAMP * 16;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [IN_W-1:0]  dat_i;
  logic             dat_valid_i;
  logic             arm_i;
  logic             trig_i;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             busy_o;
  logic             done_o;

  lpfilt_capture_reader #(
    .NBITS (NBITS),
    .NSAMP (NSAMP),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .dat_i         (dat_i),
    .dat_valid_i   (dat_valid_i),
    .arm_i         (arm_i),
    .trig_i        (trig_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    string            name;
    logic [IN_W-1:0]  word;
    logic [OUT_W-1:0] lanes;
  } vec_t;

  vec_t             vecs[5];
  logic [IN_W-1:0]  cap_words[DEPTH];
  logic [OUT_W-1:0] exp_beats[DEPTH];

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    chk_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: each sample read as a signed NBITS number, re-emitted as 16 bits.
  function automatic logic [OUT_W-1:0] ref_pack(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < NSAMP; k++) begin
      s = $signed(w[NBITS*k +: NBITS]);
      r[16*k +: 16] = 16'(s);
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_word();
    return IN_W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected();
    for (int i = 0; i < DEPTH; i++)
      exp_beats[i] = ref_pack(cap_words[i]);
  endtask

  // gap_mode: 0 = continuous valid, 1 = alternate gaps, 2 = random gaps.
  task automatic capture(input int gap_mode);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    check("armed_busy", busy_o, 1);
    // trigger without valid data must leave the block armed
    trig_i      = 1'b1;
    dat_valid_i = 1'b0;
    dat_i       = rand_word();
    step();
    trig_i = 1'b0;
    // a valid word with no trigger must not be captured
    dat_valid_i = 1'b1;
    dat_i       = ~cap_words[0];
    step();
    check("armed_hold_busy", busy_o, 1);
    trig_i      = 1'b1;
    dat_valid_i = 1'b1;
    dat_i       = cap_words[0];
    step();
    trig_i = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        dat_valid_i = 1'b0;
        dat_i       = rand_word();
        arm_i       = ($urandom_range(0, 3) == 0);
        trig_i      = ($urandom_range(0, 3) == 0);
        step();
      end
      dat_valid_i = 1'b1;
      dat_i       = cap_words[i];
      arm_i       = ($urandom_range(0, 3) == 0);
      trig_i      = ($urandom_range(0, 3) == 0);
      step();
    end
    dat_valid_i = 1'b0;
    arm_i       = 1'b0;
    trig_i      = 1'b0;
    dat_i       = rand_word();
  endtask

  // Drain the stream; abort_after >= 0 stops once that many beats were taken.
  task automatic readout(input bit rand_ready, input int abort_after);
    int          n = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = 0;
    bit          held = 0;
    bit          rdy;
    logic [OUT_W-1:0] hd;
    logic        hl;
    while (n < DEPTH && cyc < 1000) begin
      if (abort_after >= 0 && n == abort_after)
        break;
      rdy           = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = rdy;
      if (held)
        check($sformatf("beat%0d_hold_valid", n), m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check("first_valid_latency_ok", first_cyc <= 2, 1);
        end
        if (held) begin
          check($sformatf("beat%0d_hold_data", n), m_axis_tdata, hd);
          check($sformatf("beat%0d_hold_last", n), m_axis_tlast, hl);
        end
        check($sformatf("beat%0d_data", n), m_axis_tdata, exp_beats[n]);
        check($sformatf("beat%0d_last", n), m_axis_tlast, n == DEPTH - 1);
        if (rdy) begin
          if (n == DEPTH - 1) begin
            last_cyc = cyc;
            arm_i    = 1'b1;   // arm on the final handshake must be ignored
          end
          if (n == 5)
            arm_i = 1'b1;      // arm mid-readout must be ignored
          n++;
          held = 0;
        end else begin
          held = 1;
          hd   = m_axis_tdata;
          hl   = m_axis_tlast;
        end
      end
      step();
      arm_i = 1'b0;
      cyc++;
    end
    if (abort_after < 0) begin
      m_axis_tready = 1'b0;
      check("beat_count", n, DEPTH);
      check("end_done_pulse", done_o, 1);
      check("end_tvalid_low", m_axis_tvalid, 0);
      check("end_busy_low", busy_o, 0);
      if (!rand_ready)
        check("burst_cycles", last_cyc - first_cyc, DEPTH - 1);
      step();
      check("done_one_cycle", done_o, 0);
      check("rearm_ignored", busy_o, 0);
    end
    $display("readout: %0d beats in %0d cycles (rand_ready=%0d)", n, cyc, rand_ready);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"impulse",   96'h000_000_000_000_000_000_000_064,
                128'h0000_0000_0000_0000_0000_0000_0000_0064};
    vecs[1] = '{"sign_alt",  96'h000_7FF_000_800_000_7FF_000_800,
                128'h0000_07FF_0000_F800_0000_07FF_0000_F800};
    vecs[2] = '{"lane7_pos", 96'h7FF_000_000_000_000_000_000_800,
                128'h07FF_0000_0000_0000_0000_0000_0000_F800};
    vecs[3] = '{"mixed",     96'h000_000_F9C_000_001_000_FFF_000,
                128'h0000_0000_FF9C_0000_0001_0000_FFFF_0000};
    vecs[4] = '{"s0_pos",    96'h801_801_801_801_801_801_801_001,
                128'hF801_F801_F801_F801_F801_F801_F801_0001};

    rst_i         = 1'b1;
    dat_i         = '0;
    dat_valid_i   = 1'b0;
    arm_i         = 1'b0;
    trig_i        = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast, 0);
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_busy",   busy_o, 0);
    check("rst_done",   done_o, 0);
    rst_i = 1'b0;
    step();

    // trigger while idle: nothing happens
    trig_i      = 1'b1;
    dat_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dat_i = rand_word();
      step();
    end
    trig_i      = 1'b0;
    dat_valid_i = 1'b0;
    check("idle_trig_busy",   busy_o, 0);
    check("idle_trig_tvalid", m_axis_tvalid, 0);

    // table vectors as the first words of a capture, zeros after
    for (int i = 0; i < DEPTH; i++)
      cap_words[i] = '0;
    for (int i = 0; i < 5; i++)
      cap_words[i] = vecs[i].word;
    build_expected();
    for (int i = 0; i < 5; i++)
      exp_beats[i] = vecs[i].lanes;
    capture(0);
    readout(0, -1);

    // ramp with alternating gaps, random backpressure
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < NSAMP; k++)
        cap_words[i][NBITS*k +: NBITS] = NBITS'(i + 1);
    build_expected();
    capture(1);
    readout(1, -1);

    // reset in the middle of readout
    for (int i = 0; i < DEPTH; i++)
      cap_words[i] = rand_word();
    build_expected();
    capture(2);
    readout(0, 11);
    m_axis_tready = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tlast",  m_axis_tlast, 0);
    check("midrst_tdata",  m_axis_tdata, 0);
    check("midrst_busy",   busy_o, 0);
    #2 rst_i = 1'b0;
    step();

    // new capture after reset restarts at beat 0
    for (int i = 0; i < DEPTH; i++)
      cap_words[i] = rand_word();
    build_expected();
    capture(2);
    readout(1, -1);

    // fresh arm/trig cycle after done
    for (int i = 0; i < DEPTH; i++)
      cap_words[i] = rand_word();
    build_expected();
    capture(0);
    readout(0, -1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
